// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM/WB stage types and constants.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [31:0] DEF_ADDR_BASE = 32'd1024;
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) & ~32'd3;
  endfunction
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts consecutive ACCESS cycles and flags the TIMEOUT-th one.
module mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = active && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= active ? cnt + 1'b1 : '0;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with data-memory handshake FSM.
// Optional access timeout and sticky mem_error enabled by macro MEM_TIMEOUT_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN_in,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] ST_Val,
  input  logic [4:0]  Dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        WB_Write_Enable,
  output logic [4:0]  WB_Dest,
  output logic [31:0] WB_Data,
  output logic        freeze,
  output logic        mem_error
);
  state_t     state, state_nxt;
  logic       is_mem, expired, sv_en;
  logic [4:0] sv_dest;
  assign is_mem = MEM_R_EN | MEM_W_EN;
  assign freeze = (state == IDLE && valid_in && is_mem) || state == ACCESS;
`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .active(state == ACCESS),
    .expired(expired)
  );
  // ack on the expiring cycle is a normal completion
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_error <= 1'b0;
    else if (expired && !mem_ack) mem_error <= 1'b1;
`else
  assign expired   = 1'b0;
  assign mem_error = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    if (state == IDLE && valid_in && is_mem) state_nxt = ACCESS;
    else if (state == ACCESS && (mem_ack || expired)) state_nxt = DONE;
    else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // mem_we doubles as the saved store flag; R+W together is a store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      WB_Write_Enable <= 1'b0;
      WB_Dest         <= '0;
      WB_Data         <= '0;
      sv_en           <= 1'b0;
      sv_dest         <= '0;
    end else begin
      WB_Write_Enable <= 1'b0;
      if (state == IDLE && valid_in && is_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= MEM_W_EN;
        mem_addr  <= word_offset(ALU_Res, ADDR_BASE);
        mem_wdata <= ST_Val;
        sv_en     <= WB_EN_in;
        sv_dest   <= Dest_in;
      end else if (state == IDLE && valid_in) begin
        WB_Write_Enable <= WB_EN_in && |Dest_in;
        WB_Dest         <= Dest_in;
        WB_Data         <= ALU_Res;
      end else if (state == ACCESS && mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          WB_Write_Enable <= sv_en && |sv_dest;
          WB_Dest         <= sv_dest;
          WB_Data         <= mem_rdata;
        end
      end else if (state == ACCESS && expired) begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        valid_in = 0, MEM_R_EN = 0, MEM_W_EN = 0, WB_EN_in = 0;
  logic [31:0] ALU_Res = 0, ST_Val = 0, mem_rdata = 0;
  logic [4:0]  Dest_in = 0;
  logic        mem_ack = 0;
  logic        mem_req, mem_we, WB_Write_Enable, freeze, mem_error;
  logic [31:0] mem_addr, mem_wdata, WB_Data;
  logic [4:0]  WB_Dest;
  int          n_chk = 0, n_pass = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .WB_EN_in(WB_EN_in), .ALU_Res(ALU_Res), .ST_Val(ST_Val), .Dest_in(Dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .WB_Write_Enable(WB_Write_Enable),
    .WB_Dest(WB_Dest), .WB_Data(WB_Data), .freeze(freeze), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] sv, input logic [4:0] d);
    valid_in = 1; MEM_R_EN = r; MEM_W_EN = w; WB_EN_in = 1; ALU_Res = a; ST_Val = sv; Dest_in = d;
  endtask

  task automatic idle_in();
    valid_in = 0; MEM_R_EN = 0; MEM_W_EN = 0; WB_EN_in = 0;
  endtask

  initial begin
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", WB_Write_Enable, 0);
    chk("rst_data", WB_Data, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_err", mem_error, 0);
    step(); rst = 1; step();

    // ALU op
    issue(0, 0, 32'h2A, 0, 5); #1;
    chk("alu_freeze", freeze, 0);
    step(); idle_in();
    chk("alu_we", WB_Write_Enable, 1);
    chk("alu_dest", WB_Dest, 5);
    chk("alu_data", WB_Data, 32'h2A);
    chk("alu_freeze2", freeze, 0);
    step();
    chk("alu_pulse", WB_Write_Enable, 0);

    // destination r0 never written
    issue(0, 0, 32'h7, 0, 0);
    step(); idle_in();
    chk("r0_we", WB_Write_Enable, 0);
    chk("r0_data", WB_Data, 32'h7);

    // load with ack after 3 cycles
    issue(1, 0, 32'd1032, 32'h99, 8); #1;
    chk("ld_freeze0", freeze, 1);
    step(); idle_in(); ALU_Res = 0; ST_Val = 0;
    chk("ld_req", mem_req, 1);
    chk("ld_we", mem_we, 0);
    chk("ld_addr", mem_addr, 8);
    chk("ld_freeze1", freeze, 1);
    step();
    chk("ld_hold_req", mem_req, 1);
    chk("ld_hold_addr", mem_addr, 8);
    chk("ld_nowb", WB_Write_Enable, 0);
    step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_freeze3", freeze, 1);
    step(); mem_ack = 0; mem_rdata = 0;
    chk("ld_req_done", mem_req, 0);
    chk("ld_wb_we", WB_Write_Enable, 1);
    chk("ld_wb_dest", WB_Dest, 8);
    chk("ld_wb_data", WB_Data, 32'hDEADBEEF);
    chk("ld_freeze_done", freeze, 0);
    step();
    chk("ld_pulse", WB_Write_Enable, 0);

    // store
    issue(0, 1, 32'd1028, 32'h55, 3);
    step(); idle_in();
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 4);
    chk("st_wdata", mem_wdata, 32'h55);
    mem_ack = 1;
    step(); mem_ack = 0;
    chk("st_nowb", WB_Write_Enable, 0);
    chk("st_req_done", mem_req, 0);
    step();

    // R and W both set acts as store; unaligned address masked
    issue(1, 1, 32'd1035, 32'hA5, 4);
    step(); idle_in();
    chk("rw_we", mem_we, 1);
    chk("rw_addr", mem_addr, 8);
    mem_ack = 1; mem_rdata = 32'h1234;
    step(); mem_ack = 0;
    chk("rw_nowb", WB_Write_Enable, 0);
    step();

    // ack while idle ignored
    mem_ack = 1; mem_rdata = 32'hFFFF;
    step(); mem_ack = 0;
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_we", WB_Write_Enable, 0);
    chk("idle_ack_freeze", freeze, 0);

    // reset mid-access
    issue(1, 0, 32'd1040, 0, 9);
    step(); idle_in();
    chk("rst_mid_req0", mem_req, 1);
    #2 rst = 0; #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_freeze", freeze, 0);
    step(); rst = 1;
    mem_ack = 1; mem_rdata = 32'hBAD;
    step(); mem_ack = 0;
    chk("rst_mid_nowb", WB_Write_Enable, 0);
    chk("rst_mid_req2", mem_req, 0);
    step();

`ifdef MEM_TIMEOUT_EN
    // no ack: 15 ACCESS cycles then error
    issue(1, 0, 32'd1024, 0, 6);
    step(); idle_in();
    repeat (14) step();
    chk("to_req_c15", mem_req, 1);
    chk("to_err_c15", mem_error, 0);
    step();
    chk("to_req_drop", mem_req, 0);
    chk("to_err", mem_error, 1);
    chk("to_freeze", freeze, 0);
    chk("to_nowb", WB_Write_Enable, 0);
    repeat (3) step();
    chk("to_err_sticky", mem_error, 1);
    rst = 0; #1; step(); rst = 1;
    // ack on the 15th cycle wins
    issue(1, 0, 32'd1024, 0, 6);
    step(); idle_in();
    repeat (14) step();
    mem_ack = 1; mem_rdata = 32'h77;
    step(); mem_ack = 0;
    chk("to_ack_err", mem_error, 0);
    chk("to_ack_we", WB_Write_Enable, 1);
    chk("to_ack_data", WB_Data, 32'h77);
    step();
`else
    // without timeout the access waits indefinitely
    issue(1, 0, 32'd1024, 0, 6);
    step(); idle_in();
    repeat (25) step();
    chk("wait_req", mem_req, 1);
    chk("wait_freeze", freeze, 1);
    chk("wait_err", mem_error, 0);
    mem_ack = 1; mem_rdata = 32'h77;
    step(); mem_ack = 0;
    chk("wait_we", WB_Write_Enable, 1);
    chk("wait_data", WB_Data, 32'h77);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
